// File: rtl/sram_pkg.sv
// Shared types, constants and helpers for the sram_clr_be buffer.
//   sram_state_t   : clear engine state (CLEAR while sweeping, IDLE when usable)
//   SRAM_BYTE_W    : width of one byte lane
//   SRAM_MAX_RD_LAT: largest supported read latency
//   be_merge       : byte-lane merge used by the write path and the read bypass
package sram_pkg;

  typedef enum logic {
    CLEAR,
    IDLE
  } sram_state_t;

  localparam int SRAM_BYTE_W     = 8;
  localparam int SRAM_MAX_RD_LAT = 2;

  // One byte lane: take the new byte when its enable is set, keep the old one otherwise.
  function automatic logic [SRAM_BYTE_W-1:0] be_merge(
    input logic [SRAM_BYTE_W-1:0] old_byte,
    input logic [SRAM_BYTE_W-1:0] new_byte,
    input logic                   be
  );
    return be ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/sram_clr_be_rd_pipe.sv
// sram_rd_pipe: data + valid delay line used as the optional extra read stage.
//   clk   : clock
//   reset : synchronous active-high flush (data and valid cleared)
//   din   : data entering the line
//   vin   : valid qualifier for din
//   dout  : data after STAGES cycles; holds its value while no valid passes
//   vout  : valid after STAGES cycles
module sram_rd_pipe #(
  parameter int WIDTH  = 256,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             vin,
  output logic [WIDTH-1:0] dout,
  output logic             vout
);

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    logic [WIDTH-1:0] d_in;
    logic             v_in;
    logic [WIDTH-1:0] d_reg;
    logic             v_reg;

    if (gi == 0) begin : g_first
      assign d_in = din;
      assign v_in = vin;
    end else begin : g_next
      assign d_in = g_stage[gi-1].d_reg;
      assign v_in = g_stage[gi-1].v_reg;
    end

    // Data only advances with a valid beat so the output holds between reads.
    always_ff @(posedge clk) begin
      if (reset) begin
        d_reg <= '0;
        v_reg <= 1'b0;
      end else begin
        v_reg <= v_in;
        if (v_in) begin
          d_reg <= d_in;
        end
      end
    end
  end

  assign dout = g_stage[STAGES-1].d_reg;
  assign vout = g_stage[STAGES-1].v_reg;

endmodule

// File: rtl/sram_clr_be.sv
// sram_clr_be: simple-dual-port SRAM with per-byte write enables, 1- or 2-cycle
// registered read with valid strobe, non-power-of-two depth and a sequential
// clear engine (one address per cycle after reset or clr_req).
//   clk, reset : single clock, synchronous active-high reset
//   clr_req    : pulse in IDLE to start a clear pass
//   busy       : memory unusable (reset/clear in progress)
//   ena/wea/addra/dina : write port with byte enables
//   enb/addrb  : read request
//   doutb/rvalid : read data (holds when rvalid=0) and its valid strobe
// Optional feature: define SRAM_RDW_BYPASS_EN to make a same-cycle read of the
// address being written return the newly written word instead of the old one.
module sram_clr_be
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1024,
  parameter int DATA_WIDTH = 256,
  parameter int RD_LATENCY = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              clr_req,
  output logic                              busy,
  input  logic                              ena,
  input  logic [DATA_WIDTH/SRAM_BYTE_W-1:0] wea,
  input  logic [ADDR_WIDTH-1:0]             addra,
  input  logic [DATA_WIDTH-1:0]             dina,
  input  logic                              enb,
  input  logic [ADDR_WIDTH-1:0]             addrb,
  output logic [DATA_WIDTH-1:0]             doutb,
  output logic                              rvalid
);

  localparam int                    NB        = DATA_WIDTH / SRAM_BYTE_W;
  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  sram_state_t           state_reg, state_next;
  logic [ADDR_WIDTH-1:0] clr_addr_reg, clr_addr_next;
  logic                  busy_reg, busy_next;

  logic                  port_open;
  logic                  a_in_range, b_in_range;
  logic                  wr_port, rd_accept;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [NB-1:0]         wr_be;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] rd_data_reg;
  logic                  rd_valid_reg;

  // busy trails the return to IDLE by one edge, so the port opens only once
  // both the state and the registered busy agree.
  assign port_open  = (state_reg == IDLE) && !busy_reg;
  assign a_in_range = ({1'b0, addra} < DEPTH_W);
  assign b_in_range = ({1'b0, addrb} < DEPTH_W);
  assign wr_port    = port_open && ena && a_in_range;
  assign rd_accept  = port_open && enb;
  assign busy       = busy_reg;

  // ---------------- clear engine FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= CLEAR;
      clr_addr_reg <= '0;
      busy_reg     <= 1'b1;
    end else begin
      state_reg    <= state_next;
      clr_addr_reg <= clr_addr_next;
      busy_reg     <= busy_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    clr_addr_next = clr_addr_reg;
    busy_next     = (state_reg == CLEAR);
    case (state_reg)
      CLEAR: begin
        if (clr_addr_reg == LAST_ADDR) begin
          state_next    = IDLE;
          clr_addr_next = '0;
        end else begin
          clr_addr_next = clr_addr_reg + ADDR_WIDTH'(1);
        end
      end
      IDLE: begin
        if (clr_req && !busy_reg) begin
          state_next    = CLEAR;
          clr_addr_next = '0;
          busy_next     = 1'b1;
        end
      end
      default: begin
        state_next    = CLEAR;
        clr_addr_next = '0;
      end
    endcase
  end

  // ---------------- write port (clear engine has priority) ----------------
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = addra;
    wr_data = dina;
    wr_be   = wea;
    if (state_reg == CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr_reg;
      wr_data = '0;
      wr_be   = '1;
    end else if (wr_port) begin
      wr_en   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < NB; k++) begin
        mem[wr_addr][k*SRAM_BYTE_W +: SRAM_BYTE_W] <=
          be_merge(mem[wr_addr][k*SRAM_BYTE_W +: SRAM_BYTE_W],
                   wr_data[k*SRAM_BYTE_W +: SRAM_BYTE_W], wr_be[k]);
      end
    end
  end

  // ---------------- read port ----------------
`ifdef SRAM_RDW_BYPASS_EN
  logic byp_hit;
  assign byp_hit = wr_port && (addra == addrb);
  for (genvar gi = 0; gi < NB; gi++) begin : g_byp
    assign rd_word[gi*SRAM_BYTE_W +: SRAM_BYTE_W] =
      be_merge(mem[addrb][gi*SRAM_BYTE_W +: SRAM_BYTE_W],
               dina[gi*SRAM_BYTE_W +: SRAM_BYTE_W], byp_hit && wea[gi]);
  end
`else
  assign rd_word = mem[addrb];
`endif

  // Memory output register; out-of-range reads still strobe valid with zero data.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= rd_accept;
      if (rd_accept) begin
        rd_data_reg <= b_in_range ? rd_word : '0;
      end
    end
  end

  if (RD_LATENCY == SRAM_MAX_RD_LAT) begin : g_lat2
    sram_rd_pipe #(
      .WIDTH  (DATA_WIDTH),
      .STAGES (1)
    ) u_rd_pipe (
      .clk   (clk),
      .reset (reset),
      .din   (rd_data_reg),
      .vin   (rd_valid_reg),
      .dout  (doutb),
      .vout  (rvalid)
    );
  end else begin : g_lat1
    assign doutb  = rd_data_reg;
    assign rvalid = rd_valid_reg;
  end

endmodule

// File: tb/tb_sram_clr_be.sv
module tb_sram_clr_be;

  localparam int AW    = 4;
  localparam int DEPTH = 12;
  localparam int DW    = 32;
  localparam int RL    = 2;
  localparam int NB    = DW / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          clr_req;
  logic          busy;
  logic          ena;
  logic [NB-1:0] wea;
  logic [AW-1:0] addra;
  logic [DW-1:0] dina;
  logic          enb;
  logic [AW-1:0] addrb;
  logic [DW-1:0] doutb;
  logic          rvalid;

  sram_clr_be #(
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DW),
    .RD_LATENCY (RL)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .clr_req (clr_req),
    .busy    (busy),
    .ena     (ena),
    .wea     (wea),
    .addra   (addra),
    .dina    (dina),
    .enb     (enb),
    .addrb   (addrb),
    .doutb   (doutb),
    .rvalid  (rvalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } sb_t;

  sb_t           sb_q[$];
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] last_data;
  int            cyc;
  int            n_checks;
  int            n_pass;

  // Advance to the next falling edge and retire any read the DUT presents.
  task automatic tick();
    sb_t e;
    @(negedge clk);
    cyc++;
    if (rvalid === 1'b1) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        $display("FAIL sb_unexpected_rvalid: got rvalid=1 data=%h, required no outstanding read", doutb);
      end else begin
        e = sb_q.pop_front();
        if (doutb !== e.data || cyc != e.due)
          $display("FAIL sb_read: got data=%h at cycle %0d, required %h at cycle %0d", doutb, cyc, e.data, e.due);
        else begin
          n_pass++;
          $display("read  ok: data=%h cycle=%0d", doutb, cyc);
        end
        last_data = doutb;
      end
    end else if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
      n_checks++;
      e = sb_q.pop_front();
      $display("FAIL sb_missing_rvalid: got no rvalid by cycle %0d, required data=%h at cycle %0d", cyc, e.data, e.due);
    end
  endtask

  // Drive one cycle of port traffic; when accept=1 the model and scoreboard follow it.
  task automatic drive(input logic we, input logic [NB-1:0] be, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra,
                       input logic clr, input logic accept);
    sb_t e;
    logic [DW-1:0] w;
    ena = we; wea = be; addra = wa; dina = wd;
    enb = re; addrb = ra; clr_req = clr;
    $display("drive: we=%b be=%h wa=%0d wd=%h re=%b ra=%0d clr=%b accept=%b", we, be, wa, wd, re, ra, clr, accept);
    if (accept) begin
      if (re) begin
        w = '0;
        if (int'(ra) < DEPTH) begin
          w = model[ra];
`ifdef SRAM_RDW_BYPASS_EN
          if (we && wa == ra)
            for (int k = 0; k < NB; k++) if (be[k]) w[k*8 +: 8] = wd[k*8 +: 8];
`endif
        end
        e.data = w;
        e.due  = cyc + RL;
        sb_q.push_back(e);
      end
      if (we && int'(wa) < DEPTH)
        for (int k = 0; k < NB; k++) if (be[k]) model[wa][k*8 +: 8] = wd[k*8 +: 8];
    end
    tick();
    ena = 1'b0; wea = '0; enb = 1'b0; clr_req = 1'b0;
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (busy !== 1'b0 && cnt < 100) begin
      cnt++;
      tick();
    end
  endtask

  task automatic drain();
    for (int i = 0; i < RL + 2; i++) tick();
  endtask

  task automatic model_zero();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic test_reset();
    int cnt;
    reset = 1'b1;
    sb_q.delete();
    tick();
    tick();
    n_checks++;
    if (busy !== 1'b1) $display("FAIL reset_busy: got %b, required 1", busy); else n_pass++;
    n_checks++;
    if (rvalid !== 1'b0) $display("FAIL reset_rvalid: got %b, required 0", rvalid); else n_pass++;
    n_checks++;
    if (doutb !== '0) $display("FAIL reset_doutb: got %h, required 0", doutb); else n_pass++;
    reset = 1'b0;
    wait_idle(cnt);
    n_checks++;
    if (cnt != DEPTH + 1) $display("FAIL reset_busy_len: got %0d cycles, required %0d", cnt, DEPTH + 1);
    else n_pass++;
    $display("reset: busy cycles=%0d", cnt);
    model_zero();
    for (int a = 0; a < DEPTH; a++) drive(0, '0, '0, '0, 1, AW'(a), 0, 1);
    drain();
  endtask

  task automatic test_byte_enable();
    drive(1, 4'hF, 4'd3, 32'hAABBCCDD, 0, '0, 0, 1);
    drive(1, 4'b0101, 4'd3, 32'h11223344, 0, '0, 0, 1);
    drive(0, '0, '0, '0, 1, 4'd3, 0, 1);
    drain();
    n_checks++;
    if (last_data !== 32'hAA22CC44) $display("FAIL byte_enable: got %h, required AA22CC44", last_data);
    else n_pass++;
    drive(1, 4'h0, 4'd3, 32'hFFFFFFFF, 1, 4'd3, 0, 1);
    drain();
  endtask

  task automatic test_latency();
    for (int a = 0; a < 3; a++) drive(1, 4'hF, AW'(a), 32'hC0DE0000 + 32'(a), 0, '0, 0, 1);
    for (int a = 0; a < 3; a++) drive(0, '0, '0, '0, 1, AW'(a), 0, 1);
    drain();
  endtask

  task automatic test_collision();
    logic [DW-1:0] exp;
`ifdef SRAM_RDW_BYPASS_EN
    exp = 32'hFFFFFFFF;
`else
    exp = 32'h0;
`endif
    drive(1, 4'hF, 4'd5, 32'h0, 0, '0, 0, 1);
    drive(1, 4'hF, 4'd5, 32'hFFFFFFFF, 1, 4'd5, 0, 1);
    drain();
    n_checks++;
    if (last_data !== exp) $display("FAIL collision: got %h, required %h", last_data, exp); else n_pass++;
    drive(1, 4'b0011, 4'd5, 32'h12345678, 1, 4'd5, 0, 1);
    drive(0, '0, '0, '0, 1, 4'd5, 0, 1);
    drain();
  endtask

  task automatic test_hold();
    tick();
    tick();
    n_checks++;
    if (rvalid !== 1'b0 || doutb !== last_data)
      $display("FAIL hold: got rvalid=%b doutb=%h, required rvalid=0 doutb=%h", rvalid, doutb, last_data);
    else n_pass++;
  endtask

  task automatic test_clear_traffic();
    int total, cnt;
    drive(1, 4'hF, 4'd2, 32'h5A5A5A5A, 0, '0, 1, 1);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL clr_busy_rise: got %b, required 1", busy); else n_pass++;
    total = 0;
    for (int i = 0; i < 9; i++) begin
      if (busy === 1'b1) total++;
      tick();
    end
    if (busy === 1'b1) total++;
    drive(1, 4'hF, 4'd1, 32'hC3C3C3C3, 1, 4'd1, 1, 0);
    wait_idle(cnt);
    total += cnt;
    n_checks++;
    if (total != DEPTH + 1) $display("FAIL clr_busy_len: got %0d cycles, required %0d", total, DEPTH + 1);
    else n_pass++;
    model_zero();
    drive(0, '0, '0, '0, 1, 4'd1, 0, 1);
    drive(0, '0, '0, '0, 1, 4'd2, 0, 1);
    drive(0, '0, '0, '0, 1, 4'd3, 0, 1);
    drain();
  endtask

  task automatic test_boundary();
    drive(1, 4'hF, 4'd11, 32'h0BADF00D, 0, '0, 0, 1);
    drive(1, 4'hF, 4'd12, 32'h77777777, 1, 4'd11, 0, 1);
    drive(1, 4'hF, 4'd15, 32'h66666666, 1, 4'd12, 0, 1);
    drive(0, '0, '0, '0, 1, 4'd15, 0, 1);
    drive(0, '0, '0, '0, 1, 4'd0, 0, 1);
    drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++)
      drive(1'($urandom_range(0, 1)), NB'($urandom), AW'($urandom_range(0, 13)), $urandom,
            1'($urandom_range(0, 1)), AW'($urandom_range(0, 13)), 0, 1);
    drain();
  endtask

  task automatic test_reset_mid_clear();
    int cnt;
    drive(1, 4'hF, 4'd1, 32'h00001234, 0, '0, 0, 1);
    drive(1, 4'hF, 4'd10, 32'h0000DEAD, 0, '0, 0, 1);
    drive(0, '0, '0, '0, 1, 4'd1, 0, 1);
    reset = 1'b1;
    sb_q.delete();
    tick();
    n_checks++;
    if (rvalid !== 1'b0) $display("FAIL reset_flush: got rvalid=%b, required 0", rvalid); else n_pass++;
    reset = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_idle(cnt);
    n_checks++;
    if (cnt != DEPTH + 1) $display("FAIL midclr_busy_len: got %0d cycles, required %0d", cnt, DEPTH + 1);
    else n_pass++;
    model_zero();
    drive(0, '0, '0, '0, 1, 4'd1, 0, 1);
    drive(0, '0, '0, '0, 1, 4'd10, 0, 1);
    drain();
  endtask

  initial begin
    reset = 1'b1; clr_req = 1'b0; ena = 1'b0; wea = '0; addra = '0; dina = '0;
    enb = 1'b0; addrb = '0;
    cyc = 0; n_checks = 0; n_pass = 0; last_data = '0;
    test_reset();
    test_byte_enable();
    test_latency();
    test_collision();
    test_hold();
    test_clear_traffic();
    test_boundary();
    test_back_to_back();
    test_reset_mid_clear();
    n_checks++;
    if (sb_q.size() != 0) $display("FAIL sb_leftover: got %0d reads outstanding, required 0", sb_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_clr_be.md
# sram_clr_be

Single-clock, parametrised simple-dual-port SRAM with per-byte write enables, 1- or 2-cycle read latency with a valid strobe, a non-power-of-two depth, and a sequential clear engine. It is the successor to the single-cycle-clear blk_sram and serves as the weight/clause buffer in the accelerator datapath. Clearing runs one address per cycle, so large arrays still map to block RAM, and `busy` tells upstream logic when the memory is usable.

## Interface
- `ADDR_WIDTH`, 10: address bits.
- `DEPTH`, 1024: number of words, 1 ≤ DEPTH ≤ 2^ADDR_WIDTH.
- `DATA_WIDTH`, 256: word width; must be a multiple of 8.
- `RD_LATENCY`, 1: read latency in cycles; legal values are 1 and 2 only.
- `clk`  in  1: single clock for both ports.
- `reset`  in  1: synchronous, active-high. One clock; reset is synchronous and active-high.
- `clr_req`  in  1: pulse to start a clear pass.
- `busy`  out  1: high while reset is held or a clear pass is running.
- `ena`  in  1: write-port enable.
- `wea`  in  DATA_WIDTH/8: per-byte write enables.
- `addra`  in  ADDR_WIDTH: write address.
- `dina`  in  DATA_WIDTH: write data.
- `enb`  in  1: read request.
- `addrb`  in  ADDR_WIDTH: read address.
- `doutb`  out  DATA_WIDTH: read data, registered.
- `rvalid`  out  1: `doutb` is valid this cycle.

## Operation
- FSM states are `CLEAR` and `IDLE`.
- **Reset.** On reset: state=CLEAR, clr_addr=0, busy=1, doutb=0, rvalid=0, and the read pipeline is flushed.
- **CLEAR.** Each cycle writes zero to mem[clr_addr] and increments clr_addr. When clr_addr=DEPTH-1 is written, the FSM moves to IDLE and busy drops on the next edge.
- While busy:
  - Port writes are dropped.
  - `enb` is ignored; no rvalid is generated for it.
  - `clr_req` is ignored.
- **IDLE.** `clr_req`=1 moves the FSM to CLEAR with clr_addr=0. busy=1 from the next cycle. A port write or read in that same cycle is still accepted.
- **Write.** When ena=1 and state is IDLE, byte k of mem[addra] takes dina[8k+7:8k] for every wea[k]=1. Other bytes are unchanged. wea=0 is a no-op.
- **Read.** When enb=1 and state is IDLE, the read is issued.
  - doutb/rvalid appear RD_LATENCY cycles later.
  - doutb holds its last value when rvalid=0.
- **Out-of-range address (addr ≥ DEPTH).** Writes are dropped. Reads return all-zero data with rvalid=1.
- **Same-address read and write in one cycle.** Read-first by default: the read returns the old word. See Configuration for the bypass option.
- **Reset mid-clear or mid-read.** The clear restarts at 0 and in-flight reads are discarded (rvalid=0).

## Timing
- Reset is released after edge N. Edges N+1..N+DEPTH write addresses 0..DEPTH-1. busy=0 after edge N+DEPTH+1.
- **RD_LATENCY=1.** Request at edge t; data after edge t+1 (memory register only).
- **RD_LATENCY=2.** Adds one output register stage; fully pipelined at one read per cycle.
- rvalid is a pure shifted copy of the accepted enb.

## Configuration
- Macro: `SRAM_RDW_BYPASS_EN`.
- **Defined.** A read and write to the same in-range address in the same cycle returns the new word: dina bytes where wea=1, old bytes otherwise. Latency is unchanged.
- **Undefined.** Read-first behaviour; no bypass mux is synthesised.

## Structure
- Package `sram_pkg` holds:
  - `sram_state_t` enum {CLEAR, IDLE}.
  - Constants `SRAM_BYTE_W`=8 and `SRAM_MAX_RD_LAT`=2.
  - Function `be_merge(old, new, be)`, shared by the write path and the bypass.
- Sub-module `sram_rd_pipe`: a parametrised data+valid delay line, flushed by reset. It is instantiated once for the optional second read stage.

## Test plan
- **Clear after reset.** DEPTH=12; release reset → busy=1 for exactly 13 edges; reading 0..11 then returns 0 with rvalid.
- **Byte-enable merge.** DATA_WIDTH=32: write 0xAABBCCDD with wea=4'hF to addr 3, then 0x11223344 with wea=4'b0101 → read addr 3 returns 0xAA22CC44.
- **Latency.** RD_LATENCY=2, back-to-back reads of addr 0,1,2 → rvalid high for 3 cycles starting 2 cycles after the first request, with data in order.
- **Same-address collision.** addr 5 holds 0x0; write 0xFF..FF and read addr 5 in the same cycle → returns 0 without the macro, 0xFF..FF with it.
- **Clear request with port traffic.** Pulse clr_req in IDLE alongside a write to addr 2 → the write lands, then the clear zeroes it. Write and read during busy → no effect, no rvalid.
- **Boundary and reset mid-clear.** Write to addr 12 with DEPTH=12 is dropped; a read of addr 12 gives 0 with rvalid. Assert reset at clr_addr=7 → the clear restarts at 0 and the busy count restarts.
